// File: rtl/nanci_pkg.sv
// Shared definitions for the shear sort sequencer and the PE mesh:
// state encoding, phase encoding and parameter helpers.
package nanci_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    STEP = ST_STEP,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } sort_state_t;

  // Phase kind as seen by the PEs on phase_row
  localparam logic PH_ROW = 1'b1;
  localparam logic PH_COL = 1'b0;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Row phases bracket each column phase
  function automatic int phases_of(input int log_sqrt_n);
    return 2 * log_sqrt_n + 1;
  endfunction

  function automatic int phase_w_of(input int phases);
    int w;
    w = clog2(phases);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sort_step_counter.sv
// Two-level (step, phase) counter for the shear sort sequencer.
// step wraps at SORT_CYCLES and carries into phase; phase never wraps.
module sort_step_counter #(
  parameter int SORT_CYCLES = 4,
  parameter int PHASES      = 3,
  parameter int STEP_W      = 2,
  parameter int PHASE_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  output logic [STEP_W-1:0]  step_idx,
  output logic [PHASE_W-1:0] phase_idx,
  output logic               step_last,
  output logic               last
);

  localparam logic [STEP_W-1:0]  STEP_MAX  = STEP_W'(SORT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(PHASES - 1);

  logic [STEP_W-1:0]  step_q;
  logic [PHASE_W-1:0] phase_q;
  logic               phase_last;

  assign step_last  = (step_q == STEP_MAX);
  assign phase_last = (phase_q == PHASE_MAX);
  assign last       = step_last & phase_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q  <= '0;
      phase_q <= '0;
    end else if (clear) begin
      step_q  <= '0;
      phase_q <= '0;
    end else if (inc) begin
      if (step_last) begin
        step_q <= '0;
        // Final step exits the run instead of wrapping
        if (!phase_last) begin
          phase_q <= phase_q + PHASE_W'(1);
        end
      end else begin
        step_q <= step_q + STEP_W'(1);
      end
    end
  end

  assign step_idx  = step_q;
  assign phase_idx = phase_q;

endmodule

// File: rtl/shear_sort_ctrl.sv
// Global step sequencer for the mesh shear sort.
// Issues one handshaked compare-exchange command per transposition step.
module shear_sort_ctrl
  import nanci_pkg::*;
#(
  parameter int N           = 4,
  parameter int SQRT_N      = 2,
  parameter int LOG_SQRT_N  = clog2(SQRT_N),
  parameter int SORT_CYCLES = 4,
  parameter int PHASES      = phases_of(LOG_SQRT_N),
  parameter int PHASE_W     = phase_w_of(PHASES),
  parameter int STEP_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_ready,
  output logic               busy,
  output logic               step_valid,
  output logic               phase_row,
  output logic               step_odd,
  output logic [PHASE_W-1:0] phase_idx,
  output logic [STEP_W-1:0]  step_idx,
  output logic               done
);

  if (SQRT_N * SQRT_N != N) begin : g_bad_mesh
    $error("mesh side does not match PE count");
  end
  if (LOG_SQRT_N < 1) begin : g_bad_log
    $error("LOG_SQRT_N must be at least 1");
  end
  if (SORT_CYCLES < SQRT_N) begin : g_bad_cycles
    $error("SORT_CYCLES must cover the mesh side");
  end
  if ((1 << PHASE_W) < PHASES) begin : g_bad_phase_w
    $error("PHASE_W too narrow");
  end
  if ((1 << STEP_W) < SORT_CYCLES) begin : g_bad_step_w
    $error("STEP_W too narrow");
  end

  sort_state_t state_q;
  sort_state_t state_d;

  logic cnt_clear;
  logic cnt_inc;
  logic cnt_step_last;
  logic cnt_last;

  sort_step_counter #(
    .SORT_CYCLES (SORT_CYCLES),
    .PHASES      (PHASES),
    .STEP_W      (STEP_W),
    .PHASE_W     (PHASE_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .step_idx  (step_idx),
    .phase_idx (phase_idx),
    .step_last (cnt_step_last),
    .last      (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = STEP;
        end
      end
      STEP: begin
        if (step_ready) begin
          if (cnt_last) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        state_d = STEP;
      end
      DONE: begin
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign step_valid = (state_q == STEP);
  assign done       = (state_q == DONE);
  // Gated so that idle and reset present an all-zero command
  assign phase_row  = busy & (phase_idx[0] ? PH_COL : PH_ROW);
  assign step_odd   = step_idx[0];

endmodule

// File: tb/tb_shear_sort_ctrl.sv
// Scoreboard bench for shear_sort_ctrl: expected step commands are
// queued at launch and retired on each observed handshake.
module tb_shear_sort_ctrl;

  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] st;
    logic       row;
    logic       odd;
  } cmd_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       step_ready;
  logic       busy;
  logic       step_valid;
  logic       phase_row;
  logic       step_odd;
  logic [1:0] phase_idx;
  logic [1:0] step_idx;
  logic       done;

  int total;
  int bad;

  cmd_t q[$];

  shear_sort_ctrl #(
    .N           (4),
    .SQRT_N      (2),
    .LOG_SQRT_N  (1),
    .SORT_CYCLES (4),
    .PHASES      (3),
    .PHASE_W     (2),
    .STEP_W      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step_ready (step_ready),
    .busy       (busy),
    .step_valid (step_valid),
    .phase_row  (phase_row),
    .step_odd   (step_odd),
    .phase_idx  (phase_idx),
    .step_idx   (step_idx),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_run();
    cmd_t c;
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 4; s++) begin
        c.ph  = 2'(p);
        c.st  = 2'(s);
        c.row = ~c.ph[0];
        c.odd = c.st[0];
        q.push_back(c);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, step_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cmd"}, {phase_idx, step_idx, phase_row, step_odd}, 0);
  endtask

  // Caller is at a negedge; cycle 0 ends at the next posedge.
  task automatic run(input bit pre, input bit hold,
                     input int stall_len, input bit extra);
    int dcyc;
    int steps;
    int stalled;
    cmd_t c;
    push_run();
    if (!pre) start = 1'b1;
    dcyc    = -1;
    steps   = 0;
    stalled = 0;
    for (int k = 1; k <= 100 && dcyc < 0; k++) begin
      @(negedge clk);
      start = hold || (extra && (k == 5 || k == 24));
      chk("busy", busy, 1);
      if (stall_len == 0) chk("valid_cyc", step_valid, 32'(k % 2));
      if (done) begin
        dcyc = k;
        step_ready = 1'b1;
      end else if (step_valid) begin
        if (q.size() == 0) begin
          chk("overrun", step_valid, 0);
        end else begin
          c = q[0];
          chk("cmd", {phase_idx, step_idx, phase_row, step_odd}, c);
          if (c.ph == 2'd1 && c.st == 2'd2 && stalled < stall_len) begin
            step_ready = 1'b0;
            stalled++;
          end else begin
            step_ready = 1'b1;
            void'(q.pop_front());
            steps++;
          end
        end
      end else begin
        step_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("done_cyc", dcyc, 32'(24 + stall_len));
    chk("steps", steps, 12);
    chk("stalled", stalled, 32'(stall_len));
    chk("q_left", q.size(), 0);
    @(negedge clk);
    start = hold;
    chk_zero("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    start      = 1'b0;
    step_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_zero("idle");
    end
    step_ready = 1'b1;

    run(0, 0, 0, 0);
    run(0, 0, 5, 0);
    run(0, 0, 0, 1);

    // Abort a run in phase 1 with an asynchronous reset
    q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_phase", phase_idx, 1);
    chk("mid_valid", step_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_zero("in_rst");
    end
    rst = 1'b1;
    @(negedge clk);
    chk_zero("after_rst");
    run(0, 0, 0, 0);

    // Held start: relaunch two cycles after done
    run(0, 1, 0, 0);
    run(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shear_sort_ctrl.md
Name: shear_sort_ctrl

Overview:
- Global sequencer that drives the compare-exchange steps of the mesh shear sort. Issues one step command per odd-even transposition step.
- Alternates snake-order row phases with column phases. Each phase runs SORT_CYCLES steps.
- Sits directly upstream of the PE array: its command outputs fan out to every PE. The PEs' AND-reduced ready returns as step_ready.
- Replaces free-running sort timing, so the sort can stall on slow PEs and reports a clean done.

Parameters:
- N, 4: total PEs in the mesh.
- SQRT_N, 2: mesh side length. SQRT_N*SQRT_N == N.
- LOG_SQRT_N, 1: ceil(log2(SQRT_N)). Must be at least 1.
- SORT_CYCLES, 4: transposition steps per phase. Must be at least SQRT_N.
- PHASES, 2*LOG_SQRT_N+1: total phases, row phases first and last.
- PHASE_W, 2: width of phase_idx. Must satisfy 2^PHASE_W >= PHASES.
- STEP_W, 2: width of step_idx. Must satisfy 2^STEP_W >= SORT_CYCLES.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a sort run. Sampled only in IDLE.
- step_ready, in, 1: AND of all PE ready flags. The PEs can accept or have completed the current step.
- busy, out, 1: a run is in progress.
- step_valid, out, 1: the step command is valid.
- phase_row, out, 1: 1 = row phase (snake direction resolved by PE row parity), 0 = column phase.
- step_odd, out, 1: 1 = odd pairs compare, 0 = even pairs compare. Equals step_idx[0].
- phase_idx, out, PHASE_W: current phase, 0..PHASES-1.
- step_idx, out, STEP_W: current step within the phase, 0..SORT_CYCLES-1.
- done, out, 1: single-cycle pulse when a run completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0, including both counters. Reset mid-run abandons the run. No done pulse is produced.
- FSM states: IDLE, STEP, GAP, DONE.
- IDLE:
  - busy=0, step_valid=0.
  - start=1 at a clock edge: counters are cleared and the FSM moves to STEP. step_valid goes high one cycle after start.
- STEP:
  - busy=1, step_valid=1. phase_row = ~phase_idx[0], so phases 0, 2, 4 are row phases.
  - step_valid stays high and all command fields are held stable until a valid&&ready edge.
  - On handshake with the step not final: counters advance and the FSM moves to GAP.
  - On handshake with the step final (phase_idx==PHASES-1 && step_idx==SORT_CYCLES-1): the FSM moves to DONE.
  - step_ready=0: the FSM stalls indefinitely in STEP with no timeout.
- Counter advance:
  - step_idx wraps SORT_CYCLES-1 -> 0 and increments phase_idx.
  - No wrap of phase_idx occurs; the final step exits to DONE instead.
- GAP:
  - One-cycle bubble. step_valid=0, busy=1.
  - Lets the PEs register swap results before the next compare. Then returns to STEP.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE. Counters reset to 0 on entry to IDLE.
- start while not in IDLE is ignored and never queued. start held high continuously re-launches a run from IDLE on the cycle after DONE.
- step_ready while step_valid=0 has no effect.
- Throughput with step_ready tied 1:
  - One step per 2 cycles.
  - Run length = 2*PHASES*SORT_CYCLES cycles from the first step_valid to done inclusive.

Decomposition:
- Shared package nanci_pkg holds:
  - the clog2 constant function;
  - PHASES and PHASE_W derivation;
  - FSM state encoding localparams: IDLE=0, STEP=1, GAP=2, DONE=3;
  - the ROW/COL phase encoding shared with the PE.
- One natural sub-module, sort_step_counter: a two-level (step, phase) wrap counter with inc, clear and last outputs. It is instantiated once.
- The FSM and output decode stay in shear_sort_ctrl.

Test Plan (N=4, SQRT_N=2, SORT_CYCLES=4, PHASES=3, 12 steps):
- Reset and idle:
  - Stimulus: rst low for 2 cycles, then high; start=0 for 10 cycles.
  - Required: busy, step_valid and done stay 0; phase_idx and step_idx read 0.
- Nominal run, step_ready=1:
  - Stimulus: start pulse at cycle 0.
  - Required: step_valid high on cycles 1, 3, ..., 23 (12 steps).
  - Required command sequence: (phase,step) = (0,0..3) with phase_row=1, then (1,0..3) with phase_row=0, then (2,0..3) with phase_row=1; step_odd toggles 0,1,0,1 within each phase.
  - Required: done=1 only at cycle 24; busy high on cycles 1..24.
- Stall:
  - Stimulus: step_ready=0 during the (1,2) step for 5 cycles.
  - Required: step_valid and all fields held stable at phase=1, step=2, step_odd=0 for those cycles; done is delayed by exactly 5 cycles, to cycle 29.
- Ignored start:
  - Stimulus: start pulses at cycles 5 and 24 during a run.
  - Required: the step count stays 12 and a single done is produced; the FSM is back in IDLE at cycle 25.
- Reset mid-run:
  - Stimulus: rst low asynchronously (between edges) during phase 1.
  - Required: all outputs go to 0 immediately; no done; a new start after rst release gives the full 12-step sequence from (0,0).
- Back-to-back runs:
  - Stimulus: start held high.
  - Required: runs repeat; step_valid is re-asserted on the cycle after IDLE, i.e. 2 cycles after each done.
